// File: rtl/sad_match_pkg.sv
// Shared widths, FSM state type and pixel helper for the sad_match block.
package sad_match_pkg;

    localparam int PIX_W  = 8;
    localparam int SAD_W  = 12;
    localparam int ROW_W  = 10;
    localparam int N_CAND = 4;
    localparam int N_SRH  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad_match_row4.sv
// One candidate: registers four absolute pixel differences and sums them into a row SAD.
module sad_row4
    import sad_match_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [4*PIX_W-1:0]   ref_pix_i,
    input  logic [4*PIX_W-1:0]   srh_pix_i,
    output logic [ROW_W-1:0]     row_sad_o
);

    logic [PIX_W-1:0] ad_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ad_q[i] <= '0;
        end else if (en_i) begin
            for (int i = 0; i < 4; i++)
                ad_q[i] <= abs_diff(ref_pix_i[i*PIX_W +: PIX_W], srh_pix_i[i*PIX_W +: PIX_W]);
        end
    end

    always_comb begin
        row_sad_o = '0;
        for (int i = 0; i < 4; i++) row_sad_o = row_sad_o + ROW_W'(ad_q[i]);
    end

endmodule

// File: rtl/sad_match.sv
// Block-matching SAD engine: 4 candidate offsets, 3-stage pipe, best offset per block.
// Optional static-block detection is compiled in with SAD_STATIC_EN.
//
// state | meaning
// IDLE  | no rows of a block received
// ACC   | 1..BLK_ROWS-1 rows received
// DONE  | final row of the block is in the pipe
module sad_match
    import sad_match_pkg::*;
#(
    parameter int               BLK_ROWS   = 4,
    parameter logic [SAD_W-1:0] STATIC_THR = 12'd16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_start,
    input  logic             ref_vld,
    input  logic [PIX_W-1:0] ref0,
    input  logic [PIX_W-1:0] ref1,
    input  logic [PIX_W-1:0] ref2,
    input  logic [PIX_W-1:0] ref3,
    input  logic             srh_vld,
    input  logic [PIX_W-1:0] srh0,
    input  logic [PIX_W-1:0] srh1,
    input  logic [PIX_W-1:0] srh2,
    input  logic [PIX_W-1:0] srh3,
    input  logic [PIX_W-1:0] srh4,
    input  logic [PIX_W-1:0] srh5,
    input  logic [PIX_W-1:0] srh6,
    output logic             mv_vld,
    output logic [1:0]       mv_off,
    output logic [SAD_W-1:0] sad_min,
    output logic             static_flag,
    output logic             sync_err
);

    localparam logic [1:0] LAST_ROW = 2'(BLK_ROWS - 1);

    logic [4*PIX_W-1:0]     ref_bus;
    logic [N_SRH*PIX_W-1:0] srh_bus;
    logic                   beat;

    assign ref_bus = {ref3, ref2, ref1, ref0};
    assign srh_bus = {srh6, srh5, srh4, srh3, srh2, srh1, srh0};
    assign beat    = ref_vld && srh_vld && !vsync_start;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       first_row, last_row;
    logic       sync_err_q, sync_err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_row  = (state_q != ACC);
        last_row   = (cnt_q == LAST_ROW);
        sync_err_d = sync_err_q | (ref_vld ^ srh_vld);
        if (vsync_start) begin
            state_d    = IDLE;
            cnt_d      = '0;
            sync_err_d = 1'b0;
        end else if (beat) begin
            if (last_row) begin
                state_d = DONE;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                cnt_d   = cnt_q + 2'd1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Stage 1: absolute differences, one sad_row4 per candidate offset.
    logic [ROW_W-1:0] row_sad [N_CAND];
    logic             s1_vld_q, s1_first_q, s1_last_q;

    for (genvar k = 0; k < N_CAND; k++) begin : g_cand
        sad_row4 u_row (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (beat),
            .ref_pix_i (ref_bus),
            .srh_pix_i (srh_bus[k*PIX_W +: 4*PIX_W]),
            .row_sad_o (row_sad[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_vld_q   <= beat;
            s1_first_q <= first_row;
            s1_last_q  <= last_row;
        end
    end

    // Stage 2: per-candidate accumulators; the first row of a block loads.
    logic [SAD_W-1:0] acc_q [N_CAND];
    logic [SAD_W-1:0] acc_d [N_CAND];
    logic             s2_vld_q, s2_vld_d;

    always_comb begin
        s2_vld_d = 1'b0;
        for (int k = 0; k < N_CAND; k++) acc_d[k] = acc_q[k];
        if (vsync_start) begin
            for (int k = 0; k < N_CAND; k++) acc_d[k] = '0;
        end else if (s1_vld_q) begin
            s2_vld_d = s1_last_q;
            for (int k = 0; k < N_CAND; k++)
                acc_d[k] = (s1_first_q ? '0 : acc_q[k]) + SAD_W'(row_sad[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            for (int k = 0; k < N_CAND; k++) acc_q[k] <= '0;
        end else begin
            s2_vld_q <= s2_vld_d;
            for (int k = 0; k < N_CAND; k++) acc_q[k] <= acc_d[k];
        end
    end

    // Stage 3: minimum search, strict compare so ties keep the lower offset.
    logic [SAD_W-1:0] best_sad;
    logic [1:0]       best_off;
    logic             s3_vld_q;
    logic [SAD_W-1:0] s3_sad_q;
    logic [1:0]       s3_off_q;

    always_comb begin
        best_sad = acc_q[0];
        best_off = 2'd0;
        for (int k = 1; k < N_CAND; k++) begin
            if (acc_q[k] < best_sad) begin
                best_sad = acc_q[k];
                best_off = 2'(k);
            end
        end
    end

    logic             mv_vld_q;
    logic [1:0]       mv_off_q;
    logic [SAD_W-1:0] sad_min_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q  <= 1'b0;
            s3_sad_q  <= '0;
            s3_off_q  <= '0;
            mv_vld_q  <= 1'b0;
            mv_off_q  <= '0;
            sad_min_q <= '0;
        end else begin
            s3_vld_q <= s2_vld_q && !vsync_start;
            mv_vld_q <= s3_vld_q && !vsync_start;
            if (s2_vld_q) begin
                s3_sad_q <= best_sad;
                s3_off_q <= best_off;
            end
            if (s3_vld_q && !vsync_start) begin
                mv_off_q  <= s3_off_q;
                sad_min_q <= s3_sad_q;
            end
        end
    end

`ifdef SAD_STATIC_EN
    logic s3_static_q, static_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_static_q <= 1'b0;
            static_q    <= 1'b0;
        end else begin
            if (s2_vld_q) s3_static_q <= (acc_q[0] <= STATIC_THR);
            if (s3_vld_q && !vsync_start) static_q <= s3_static_q;
        end
    end

    assign static_flag = static_q;
`else
    assign static_flag = 1'b0;
`endif

    assign mv_vld   = mv_vld_q;
    assign mv_off   = mv_off_q;
    assign sad_min  = sad_min_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_sad_match.sv
// Scoreboard bench for sad_match: a behavioural SAD model queues expected results per block.
module tb_sad_match;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync_start = 1'b0;
    logic       ref_vld = 1'b0, srh_vld = 1'b0;
    logic [7:0] ref0 = 0, ref1 = 0, ref2 = 0, ref3 = 0;
    logic [7:0] srh0 = 0, srh1 = 0, srh2 = 0, srh3 = 0, srh4 = 0, srh5 = 0, srh6 = 0;
    logic       mv_vld, static_flag, sync_err;
    logic [1:0] mv_off;
    logic [11:0] sad_min;

    sad_match dut (
        .clk(clk), .rst_n(rst_n), .vsync_start(vsync_start),
        .ref_vld(ref_vld), .ref0(ref0), .ref1(ref1), .ref2(ref2), .ref3(ref3),
        .srh_vld(srh_vld), .srh0(srh0), .srh1(srh1), .srh2(srh2), .srh3(srh3),
        .srh4(srh4), .srh5(srh5), .srh6(srh6),
        .mv_vld(mv_vld), .mv_off(mv_off), .sad_min(sad_min),
        .static_flag(static_flag), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [1:0] off;
        logic [11:0] sad;
        logic       stat;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   ncyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   m_acc[4];
    int   m_cnt = 0;

    // Monitor: sample outputs on the falling edge.
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (mv_vld === 1'b1) begin
            res_t g;
            g.stamp = ncyc; g.off = mv_off; g.sad = sad_min; g.stat = static_flag;
            got_q.push_back(g);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rp(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [55:0] sp_lin(input int base, input int step);
        logic [55:0] s;
        for (int i = 0; i < 7; i++) s[i*8 +: 8] = 8'(base + i*step);
        return s;
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        for (int k = 0; k < 4; k++) m_acc[k] = 0;
    endtask

    task automatic drive_beat(input logic [31:0] r, input logic [55:0] s, input logic vs);
        @(negedge clk); #1;
        ref_vld = 1'b1; srh_vld = 1'b1; vsync_start = vs;
        ref0 = r[7:0]; ref1 = r[15:8]; ref2 = r[23:16]; ref3 = r[31:24];
        srh0 = s[7:0]; srh1 = s[15:8]; srh2 = s[23:16]; srh3 = s[31:24];
        srh4 = s[39:32]; srh5 = s[47:40]; srh6 = s[55:48];
        if (vs) begin
            model_clear();
        end else begin
            for (int k = 0; k < 4; k++) begin
                int row = 0;
                for (int i = 0; i < 4; i++) begin
                    int a = int'(r[i*8 +: 8]);
                    int b = int'(s[(i+k)*8 +: 8]);
                    row += (a > b) ? a - b : b - a;
                end
                m_acc[k] = (m_cnt == 0) ? row : m_acc[k] + row;
            end
            m_cnt++;
            if (m_cnt == 4) begin
                res_t e;
                int best = m_acc[0];
                e.off = 0;
                for (int k = 1; k < 4; k++) if (m_acc[k] < best) begin best = m_acc[k]; e.off = 2'(k); end
                e.sad = 12'(best);
                e.stamp = ncyc + 4;
`ifdef SAD_STATIC_EN
                e.stat = (m_acc[0] <= 16);
`else
                e.stat = 1'b0;
`endif
                exp_q.push_back(e);
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk); #1;
        ref_vld = 1'b0; srh_vld = 1'b0; vsync_start = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, output bit ok);
        for (int i = 0; i < 40 && got_q.size() < n; i++) @(negedge clk);
        #1;
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({mv_vld, mv_off, sad_min, static_flag, sync_err} !== 17'd0) begin
            errors++; $display("FAIL reset_outputs: got vld=%b off=%0d sad=%0d st=%b se=%b, need all 0",
                               mv_vld, mv_off, sad_min, static_flag, sync_err);
        end
        rst_n = 1'b1;
        model_clear();
        idle(2);
        checks++; if (mv_vld !== 1'b0 || sync_err !== 1'b0) begin
            errors++; $display("FAIL reset_release: got vld=%b se=%b, need 0 0", mv_vld, sync_err);
        end
    endtask

    task automatic test_match();
        bit ok; res_t e, g;
        repeat (4) drive_beat(rp(10, 20, 30, 40), sp_lin(0, 10), 1'b0);
        idle(0);
        wait_got(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL match_timeout: got %0d results, need 1", got_q.size()); return; end
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g.off !== 2'd1 || g.sad !== 12'd0 || g.stamp !== e.stamp || g.stat !== e.stat) begin
            errors++; $display("FAIL match: got off=%0d sad=%0d t=%0d st=%b, need off=1 sad=0 t=%0d st=%b",
                               g.off, g.sad, g.stamp, g.stat, e.stamp, e.stat);
        end
    endtask

    task automatic test_saturate();
        bit ok; res_t e, g;
        repeat (4) drive_beat(rp(0, 0, 0, 0), sp_lin(255, 0), 1'b0);
        idle(0);
        wait_got(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: got %0d results, need 1", got_q.size()); return; end
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g.off !== 2'd0 || g.sad !== 12'd4080 || g.stamp !== e.stamp || g.stat !== e.stat) begin
            errors++; $display("FAIL saturate: got off=%0d sad=%0d t=%0d st=%b, need off=0 sad=4080 t=%0d st=%b",
                               g.off, g.sad, g.stamp, g.stat, e.stamp, e.stat);
        end
        idle(5);
        checks++; if (mv_vld !== 1'b0 || mv_off !== 2'd0 || sad_min !== 12'd4080) begin
            errors++; $display("FAIL hold: got vld=%b off=%0d sad=%0d, need 0 0 4080", mv_vld, mv_off, sad_min);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; res_t e, g;
        repeat (2) drive_beat(rp(5, 6, 7, 8), sp_lin(1, 3), 1'b0);
        @(negedge clk); #1;
        ref_vld = 1'b0; srh_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (sad_min !== 12'd0 || mv_off !== 2'd0) begin
            errors++; $display("FAIL async_reset: got sad=%0d off=%0d, need 0 0", sad_min, mv_off);
        end
        model_clear();
        @(negedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        repeat (4) drive_beat(rp(30, 40, 50, 60), sp_lin(10, 10), 1'b0);
        idle(0);
        wait_got(1, ok);
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d results, need 1", got_q.size()); return; end
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g.off !== 2'd2 || g.sad !== 12'd0 || g.stamp !== e.stamp) begin
            errors++; $display("FAIL rstmid: got off=%0d sad=%0d t=%0d, need off=2 sad=0 t=%0d", g.off, g.sad, g.stamp, e.stamp);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; res_t e1, g1, e2, g2;
        repeat (4) drive_beat(rp(10, 20, 30, 40), sp_lin(0, 10), 1'b0);
        repeat (4) drive_beat(rp(30, 40, 50, 60), sp_lin(0, 10), 1'b0);
        idle(0);
        wait_got(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d results, need 2", got_q.size()); return; end
        e1 = exp_q.pop_front(); g1 = got_q.pop_front();
        e2 = exp_q.pop_front(); g2 = got_q.pop_front();
        checks++; if (g2.stamp - g1.stamp !== 4) begin
            errors++; $display("FAIL b2b_gap: got %0d cycles, need 4", g2.stamp - g1.stamp);
        end
        checks++; if (g1.off !== 2'd1 || g1.sad !== 12'd0 || g1.stamp !== e1.stamp) begin
            errors++; $display("FAIL b2b_first: got off=%0d sad=%0d t=%0d, need off=1 sad=0 t=%0d", g1.off, g1.sad, g1.stamp, e1.stamp);
        end
        checks++; if (g2.off !== 2'd3 || g2.sad !== 12'd0 || g2.stamp !== e2.stamp) begin
            errors++; $display("FAIL b2b_second: got off=%0d sad=%0d t=%0d, need off=3 sad=0 t=%0d", g2.off, g2.sad, g2.stamp, e2.stamp);
        end
    endtask

    task automatic test_vsync();
        bit ok; res_t e, g;
        repeat (2) drive_beat(rp(1, 2, 3, 4), sp_lin(9, 1), 1'b0);
        drive_beat(rp(1, 2, 3, 4), sp_lin(9, 1), 1'b1);
        idle(10);
        checks++; if (got_q.size() != 0) begin
            errors++; $display("FAIL vsync_kill: got %0d results, need 0", got_q.size());
            got_q.delete();
        end
        repeat (4) drive_beat(rp(100, 90, 80, 70), sp_lin(110, 250), 1'b0);
        idle(0);
        wait_got(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL vsync_timeout: got %0d results, need 1", got_q.size()); return; end
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g.off !== e.off || g.sad !== e.sad || g.stamp !== e.stamp) begin
            errors++; $display("FAIL vsync_after: got off=%0d sad=%0d t=%0d, need off=%0d sad=%0d t=%0d",
                               g.off, g.sad, g.stamp, e.off, e.sad, e.stamp);
        end
    endtask

    task automatic test_sync_err();
        bit ok; res_t e, g;
        @(negedge clk); #1;
        ref_vld = 1'b1; srh_vld = 1'b0;
        ref0 = 8'd200; ref1 = 8'd200; ref2 = 8'd200; ref3 = 8'd200;
        idle(2);
        checks++; if (sync_err !== 1'b1) begin
            errors++; $display("FAIL sync_set: got %b, need 1", sync_err);
        end
        repeat (4) drive_beat(rp(7, 7, 7, 7), sp_lin(3, 2), 1'b0);
        idle(0);
        wait_got(1, ok);
        checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL sync_count: got %0d results, need 1", got_q.size()); return; end
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++; if (g.off !== e.off || g.sad !== e.sad || g.stamp !== e.stamp || sync_err !== 1'b1) begin
            errors++; $display("FAIL sync_drop: got off=%0d sad=%0d t=%0d se=%b, need off=%0d sad=%0d t=%0d se=1",
                               g.off, g.sad, g.stamp, sync_err, e.off, e.sad, e.stamp);
        end
        @(negedge clk); #1;
        vsync_start = 1'b1;
        idle(1);
        checks++; if (sync_err !== 1'b0) begin
            errors++; $display("FAIL sync_clear: got %b, need 0", sync_err);
        end
    endtask

    task automatic test_static();
        bit ok; res_t e, g;
        logic [55:0] s;
        for (int thr = 16; thr <= 17; thr++) begin
            s = '0; s[7:0] = 8'd4;
            drive_beat(rp(0, 0, 0, 0), s, 1'b0);
            s[7:0] = 8'(4 + thr - 16);
            drive_beat(rp(0, 0, 0, 0), s, 1'b0);
            s[7:0] = 8'd4;
            repeat (2) drive_beat(rp(0, 0, 0, 0), s, 1'b0);
            idle(0);
            wait_got(1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL static_timeout: thr=%0d", thr); return; end
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g.stat !== e.stat || g.off !== 2'd1 || g.sad !== 12'd0) begin
                errors++; $display("FAIL static_%0d: got st=%b off=%0d sad=%0d, need st=%b off=1 sad=0",
                                   thr, g.stat, g.off, g.sad, e.stat);
            end
        end
    endtask

    task automatic test_random();
        bit ok; res_t e, g;
        for (int b = 0; b < 3; b++)
            repeat (4) drive_beat($urandom, {$urandom, $urandom}, 1'b0);
        idle(0);
        wait_got(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: got %0d results, need 3", got_q.size()); return; end
        for (int b = 0; b < 3; b++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g.off !== e.off || g.sad !== e.sad || g.stamp !== e.stamp || g.stat !== e.stat) begin
                errors++; $display("FAIL rand_%0d: got off=%0d sad=%0d t=%0d st=%b, need off=%0d sad=%0d t=%0d st=%b",
                                   b, g.off, g.sad, g.stamp, g.stat, e.off, e.sad, e.stamp, e.stat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        test_vsync();
        test_sync_err();
        test_static();
        test_random();
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sad_match.md
SAD_MATCH -- requirements
Module: sad_match

Interface
REQ-001 SHALL have parameter BLK_ROWS, default 4, rows per block (legal 1..4).
REQ-002 SHALL have parameter STATIC_THR, default 12'd16, static-block SAD threshold.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port vsync_start  input  1  frame-start pulse, clears block state.
REQ-006 SHALL have port ref_vld  input  1  reference row beat valid.
REQ-007 SHALL have ports ref0..ref3  input  8 each  reference pixels, ref0 leftmost.
REQ-008 SHALL have port srh_vld  input  1  search row beat valid.
REQ-009 SHALL have ports srh0..srh6  input  8 each  search pixels, srh0 leftmost.
REQ-010 SHALL have port mv_vld  output  1  one-cycle result strobe.
REQ-011 SHALL have port mv_off  output  2  best candidate offset 0..3.
REQ-012 SHALL have port sad_min  output  12  SAD of best candidate.
REQ-013 SHALL have port static_flag  output  1  block static indicator, qualified by mv_vld.
REQ-014 SHALL have port sync_err  output  1  sticky ref/srh misalignment flag.

Function
REQ-015 Beat accepted SHALL be ref_vld && srh_vld in the same cycle.
REQ-016 Candidate k (0..3) row SAD SHALL be sum over i=0..3 of |ref_i - srh_(i+k)|, 8-bit unsigned, 10-bit result.
REQ-017 Stage 1 SHALL register 16 absolute differences; stage 2 SHALL add row SADs into four 12-bit accumulators; stage 3 SHALL register the minimum.
REQ-018 mv_vld SHALL pulse exactly 3 cycles after the edge sampling the BLK_ROWS-th accepted beat.
REQ-019 Minimum ties SHALL resolve to the lowest offset.
REQ-020 FSM states SHALL be IDLE (no rows), ACC (1..BLK_ROWS-1 rows), DONE (final row in pipe); IDLE->ACC on first beat, ACC->DONE on BLK_ROWS-th beat, DONE->ACC on a beat in the same cycle as the accumulator restart, else DONE->IDLE.
REQ-021 Back-to-back blocks with no idle cycle SHALL be supported; accumulators SHALL load (not add) on the first row of a block.
REQ-022 ref_vld xor srh_vld SHALL drop the beat and set sync_err; sync_err SHALL clear only on vsync_start or reset.
REQ-023 vsync_start SHALL clear row counter, accumulators, pipeline valids and FSM to IDLE; a beat in the same cycle SHALL be dropped; no mv_vld SHALL emerge from a cleared block.
REQ-024 mv_off, sad_min, static_flag SHALL hold their last values between mv_vld strobes.

Reset
REQ-025 rst_n low SHALL asynchronously force mv_vld=0, mv_off=0, sad_min=0, static_flag=0, sync_err=0, FSM=IDLE, counters and accumulators 0.
REQ-026 Reset mid-block SHALL discard the partial block; first block after release SHALL start at row 0.

Configuration
REQ-027 Macro SAD_STATIC_EN defined: static_flag = (candidate-0 SAD <= STATIC_THR), registered with mv_vld.
REQ-028 SAD_STATIC_EN undefined: static_flag tied 0, no comparator logic.

Structure
REQ-029 Package sad_match_pkg SHALL hold PIX_W=8, SAD_W=12, N_CAND=4, N_SRH=7 and the FSM state enum.
REQ-030 Sub-module sad_row4 (one candidate's 4-pixel abs-diff and row sum) SHALL be instantiated N_CAND times.

Verification
REQ-031 ref=10,20,30,40; srh=0,10,20,30,40,50,60 for 4 beats -> mv_off=1, sad_min=0, mv_vld 3 cycles after beat 4.
REQ-032 ref all 0, srh all 255 for 4 beats -> sad_min=4080, mv_off=0 (tie), no overflow.
REQ-033 Two blocks back-to-back, block 2 best at offset 3 -> two mv_vld pulses 4 cycles apart, second mv_off=3.
REQ-034 vsync_start asserted with beat 3 of a block -> no mv_vld; next 4 beats give a correct standalone result.
REQ-035 ref_vld=1, srh_vld=0 for one cycle -> beat dropped, sync_err=1 until vsync_start.
REQ-036 SAD_STATIC_EN defined, offset-0 SAD=16 -> static_flag=1; SAD=17 -> static_flag=0; undefined -> always 0.
